// File: rtl/snake_pkg.sv
// snake_pkg: direction codes, keypad map and debounce states shared by the keypad front end
package snake_pkg;
   localparam logic [1:0] DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11;
   // Row/column of each direction key, indexed by direction code
   localparam logic [3:0][1:0] KEY_ROW = {2'd1, 2'd1, 2'd2, 2'd0};
   localparam logic [3:0][1:0] KEY_COL = {2'd2, 2'd0, 2'd1, 2'd1};
   typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_HELD} deb_state_e;
   function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
      return (a ^ b) == 2'b01;
   endfunction
endpackage

// File: rtl/snake_keypad_scan_if.sv
// snake_keypad_scan_if: keypad pins and direction outputs of the snake keypad front end
interface snake_keypad_scan_if;
   logic [3:0] keypad_col;
   logic [3:0] keypad_row;
   logic [1:0] direction;
   logic       dir_valid;
   modport slave (input keypad_col, output keypad_row, direction, dir_valid);
   modport master (output keypad_col, input keypad_row, direction, dir_valid);
endinterface

// File: rtl/snake_keypad_scan_row_scanner.sv
// keypad_row_scanner: walks the active-low row drive and folds each frame of column samples
// into one registered result (exactly one direction key, or none/conflict).
module keypad_row_scanner
   import snake_pkg::*;
#(
   parameter int ROW_DWELL = 4
) (
   input  logic       clk10000,
   input  logic       rst,
   input  logic [3:0] keypad_col_i,
   output logic [3:0] keypad_row_o,
   output logic       frame_done_o,
   output logic       frame_key_o,
   output logic [1:0] frame_dir_o
);
   localparam int DW = ROW_DWELL > 1 ? $clog2(ROW_DWELL) : 1;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0] row_q, row_d, dir_q, dir_d;
   logic [3:0] seen_q, seen_d, hit, seen;
   logic done_q, done_d, key_q, key_d, last, frame_end;
   always_comb begin
      for (int d = 0; d < 4; d++) hit[d] = row_q == KEY_ROW[d] && !keypad_col_i[KEY_COL[d]];
      last = dwell_q == DW'(ROW_DWELL - 1);
      frame_end = last && row_q == 2'd3;
      seen = seen_q | hit;
      dwell_d = last ? '0 : dwell_q + DW'(1);
      row_d = last ? row_q + 2'd1 : row_q;
      seen_d = frame_end ? '0 : last ? seen : seen_q;
      done_d = frame_end;
      key_d = frame_end ? $onehot(seen) : key_q;
      dir_d = !frame_end ? dir_q : seen[DIR_DOWN] ? DIR_DOWN : seen[DIR_LEFT] ? DIR_LEFT :
              seen[DIR_RIGHT] ? DIR_RIGHT : DIR_UP;
   end
   always_ff @(posedge clk10000) begin
      if (rst) begin
         dwell_q <= '0;
         row_q <= '0;
         seen_q <= '0;
         done_q <= 1'b0;
         key_q <= 1'b0;
         dir_q <= DIR_UP;
      end else begin
         dwell_q <= dwell_d;
         row_q <= row_d;
         seen_q <= seen_d;
         done_q <= done_d;
         key_q <= key_d;
         dir_q <= dir_d;
      end
   end
   assign keypad_row_o = ~(4'b0001 << row_q);
   assign frame_done_o = done_q;
   assign frame_key_o = key_q;
   assign frame_dir_o = dir_q;
endmodule

// File: rtl/snake_keypad_scan.sv
// snake_keypad_scan: debounced 4x4 keypad to snake direction front end.
// Define SNAKE_REVERSE_GUARD_EN to drop accepted keys that would reverse the snake.
module snake_keypad_scan
   import snake_pkg::*;
#(
   parameter int ROW_DWELL = 4,
   parameter int DEBOUNCE = 8
) (
   input logic clk10000,
   input logic rst,
   snake_keypad_scan_if.slave bus
);
`ifdef SNAKE_REVERSE_GUARD_EN
   localparam logic GUARD = 1'b1;
`else
   localparam logic GUARD = 1'b0;
`endif
   deb_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] cand_q, cand_d, dir_q, dir_d, frame_dir;
   logic valid_q, valid_d, frame_done, frame_key, restart, accept;
   keypad_row_scanner #(.ROW_DWELL(ROW_DWELL)) u_scan (
      .clk10000     (clk10000),
      .rst          (rst),
      .keypad_col_i (bus.keypad_col),
      .keypad_row_o (bus.keypad_row),
      .frame_done_o (frame_done),
      .frame_key_o  (frame_key),
      .frame_dir_o  (frame_dir)
   );
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      cand_d = cand_q;
      dir_d = dir_q;
      valid_d = 1'b0;
      accept = 1'b0;
      restart = state_q == ST_IDLE || cand_q != frame_dir;
      if (frame_done && !frame_key) begin
         state_d = ST_IDLE;
         cnt_d = '0;
      end else if (frame_done && state_q != ST_HELD) begin
         cand_d = frame_dir;
         cnt_d = restart ? 4'd1 : cnt_q + 4'd1;
         accept = cnt_d == 4'(DEBOUNCE);
         state_d = accept ? ST_HELD : ST_COUNT;
      end
      // A held key never re-accepts; repeats and optional reversals leave direction alone
      if (accept && frame_dir != dir_q && !(GUARD && is_reverse(frame_dir, dir_q))) begin
         dir_d = frame_dir;
         valid_d = 1'b1;
      end
   end
   always_ff @(posedge clk10000) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q <= '0;
         cand_q <= DIR_UP;
         dir_q <= DIR_RIGHT;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         cand_q <= cand_d;
         dir_q <= dir_d;
         valid_q <= valid_d;
      end
   end
   assign bus.direction = dir_q;
   assign bus.dir_valid = valid_q;
endmodule

// File: tb/tb_snake_keypad_scan.sv
// tb_snake_keypad_scan: frame-level keypad stimulus checked against a run-length debounce model
module tb_snake_keypad_scan;
`ifdef SNAKE_REVERSE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   localparam int DEBOUNCE = 8;
   localparam int KB[4] = '{1, 9, 4, 6};
   localparam logic [15:0] IGN = 16'hFDAD;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] keys = '0;
   int vectors = 0, fails = 0;
   int m_dir, m_run, m_prev, m_held, m_p;
   snake_keypad_scan_if bus ();
   snake_keypad_scan #(.ROW_DWELL(4), .DEBOUNCE(DEBOUNCE)) dut (
      .clk10000 (clk),
      .rst      (rst),
      .bus      (bus)
   );
   always #5 clk = ~clk;
   always_comb begin
      bus.keypad_col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!bus.keypad_row[r] && keys[r*4+c]) bus.keypad_col[c] = 1'b0;
   end
   function automatic logic [15:0] kb(input int d);
      return 16'(1) << KB[d];
   endfunction
   function automatic void model_reset();
      m_dir = 3; m_run = 0; m_prev = -1; m_held = 0; m_p = 0;
   endfunction
   function automatic void model(input logic [15:0] k);
      int n = 0, key = -1;
      for (int d = 0; d < 4; d++) if (k[KB[d]]) begin n++; key = d; end
      if (n != 1) key = -1;
      m_run = key < 0 ? 0 : key == m_prev ? m_run + 1 : 1;
      m_prev = key;
      m_p = 0;
      if (key < 0) m_held = 0;
      else if (!m_held && m_run == DEBOUNCE) begin
         m_held = 1;
         if (key != m_dir && !(GUARD && key / 2 == m_dir / 2)) begin
            m_dir = key;
            m_p = 1;
         end
      end
   endfunction
   task automatic do_reset();
      rst = 1'b1;
      keys = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask
   task automatic frame(input logic [15:0] k, output logic [1:0] od, output int np, output int pos);
      keys = k;
      np = 0;
      pos = 0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         #1;
         if (bus.dir_valid === 1'b1) begin
            np++;
            if (pos == 0) pos = i;
         end
      end
      od = bus.direction;
   endtask
   task automatic test_reset();
      logic [3:0] er;
      do_reset();
      vectors++;
      if (bus.keypad_row !== 4'b1110 || bus.direction !== 2'b11 || bus.dir_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset: row=%b dir=%b valid=%b, expected 1110/11/0", bus.keypad_row, bus.direction, bus.dir_valid);
      end
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         #1;
         er = ~(4'b0001 << ((i % 16) / 4));
         vectors++;
         if (bus.keypad_row !== er) begin
            fails++;
            $display("FAIL row_scan cycle %0d: row=%b expected %b", i, bus.keypad_row, er);
         end
      end
      model(16'h0);
   endtask
   task automatic test_hold_up();
      logic [15:0] k; logic [1:0] od, ed; int np, pos, ep, total = 0, first = -1;
      do_reset();
      for (int f = 0; f < 11; f++) begin
         k = (f < 10 ? kb(0) : 16'h0) | (16'($urandom) & IGN);
         ed = 2'(m_dir); ep = m_p;
         frame(k, od, np, pos);
         total += np;
         if (np > 0 && first < 0) first = f * 16 + pos;
         vectors++;
         if (od !== ed || np != ep || (ep == 1 && pos != 1)) begin
            fails++;
            $display("FAIL hold_up frame %0d: dir=%b pulses=%0d at=%0d, expected dir=%b pulses=%0d at=1", f, od, np, pos, ed, ep);
         end
         model(k);
      end
      vectors++;
      if (total != 1 || first != 129 || bus.direction !== 2'b00) begin
         fails++;
         $display("FAIL hold_up_latency: pulses=%0d first=%0d dir=%b, expected 1/129/00", total, first, bus.direction);
      end
   endtask
   task automatic test_release_repress();
      logic [15:0] k; logic [1:0] od, ed; int np, pos, ep, total = 0;
      for (int f = 0; f < 17; f++) begin
         k = (f == 7 || f == 16 ? 16'h0 : kb(2)) | (16'($urandom) & IGN);
         ed = 2'(m_dir); ep = m_p;
         frame(k, od, np, pos);
         total += np;
         vectors++;
         if (od !== ed || np != ep || (ep == 1 && pos != 1)) begin
            fails++;
            $display("FAIL release frame %0d: dir=%b pulses=%0d at=%0d, expected dir=%b pulses=%0d at=1", f, od, np, pos, ed, ep);
         end
         model(k);
      end
      vectors++;
      if (total != 1 || bus.direction !== 2'b10) begin
         fails++;
         $display("FAIL release_total: pulses=%0d dir=%b, expected 1/10", total, bus.direction);
      end
   endtask
   task automatic test_conflict();
      logic [15:0] k; logic [1:0] od, ed; int np, pos, ep, total = 0;
      for (int f = 0; f < 21; f++) begin
         k = (f < 20 ? kb(0) | kb(2) : 16'h0) | (16'($urandom) & IGN);
         ed = 2'(m_dir); ep = m_p;
         frame(k, od, np, pos);
         total += np;
         vectors++;
         if (od !== ed || np != ep) begin
            fails++;
            $display("FAIL conflict frame %0d: dir=%b pulses=%0d, expected dir=%b pulses=%0d", f, od, np, ed, ep);
         end
         model(k);
      end
      vectors++;
      if (total != 0 || bus.direction !== 2'b10) begin
         fails++;
         $display("FAIL conflict_total: pulses=%0d dir=%b, expected 0/10", total, bus.direction);
      end
   endtask
   task automatic test_reverse();
      logic [15:0] k; logic [1:0] od, ed; int np, pos, ep, total = 0;
      do_reset();
      for (int f = 0; f < 11; f++) begin
         k = f < 10 ? kb(2) : 16'h0;
         ed = 2'(m_dir); ep = m_p;
         frame(k, od, np, pos);
         total += np;
         vectors++;
         if (od !== ed || np != ep || (ep == 1 && pos != 1)) begin
            fails++;
            $display("FAIL reverse frame %0d: dir=%b pulses=%0d at=%0d, expected dir=%b pulses=%0d at=1", f, od, np, pos, ed, ep);
         end
         model(k);
      end
      vectors++;
      if (total != (GUARD ? 0 : 1) || bus.direction !== (GUARD ? 2'b11 : 2'b10)) begin
         fails++;
         $display("FAIL reverse_total: pulses=%0d dir=%b, expected %0d/%b", total, bus.direction, GUARD ? 0 : 1, GUARD ? 2'b11 : 2'b10);
      end
   endtask
   task automatic test_rst_mid();
      logic [15:0] k; logic [1:0] od, ed; int np, pos, ep, total = 0;
      for (int f = 0; f < 15; f++) begin
         k = f < 9 ? kb(1) : f == 9 ? 16'h0 : kb(0);
         ed = 2'(m_dir); ep = m_p;
         frame(k, od, np, pos);
         vectors++;
         if (od !== ed || np != ep || (ep == 1 && pos != 1)) begin
            fails++;
            $display("FAIL pre_rst frame %0d: dir=%b pulses=%0d at=%0d, expected dir=%b pulses=%0d at=1", f, od, np, pos, ed, ep);
         end
         model(k);
      end
      repeat (7) @(posedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (bus.keypad_row !== 4'b1110 || bus.direction !== 2'b11 || bus.dir_valid !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: row=%b dir=%b valid=%b, expected 1110/11/0", bus.keypad_row, bus.direction, bus.dir_valid);
      end
      rst = 1'b0;
      model_reset();
      for (int f = 0; f < 9; f++) begin
         k = f < 8 ? kb(0) : 16'h0;
         ed = 2'(m_dir); ep = m_p;
         frame(k, od, np, pos);
         total += np;
         vectors++;
         if (od !== ed || np != ep || (ep == 1 && pos != 1)) begin
            fails++;
            $display("FAIL post_rst frame %0d: dir=%b pulses=%0d at=%0d, expected dir=%b pulses=%0d at=1", f, od, np, pos, ed, ep);
         end
         model(k);
      end
      vectors++;
      if (total != 1 || bus.direction !== 2'b00) begin
         fails++;
         $display("FAIL post_rst_total: pulses=%0d dir=%b, expected 1/00", total, bus.direction);
      end
   endtask
   task automatic test_random();
      logic [15:0] k; logic [1:0] od, ed; int np, pos, ep, sel, len;
      for (int run = 0; run < 30; run++) begin
         sel = $urandom_range(0, 5);
         len = $urandom_range(1, 11);
         for (int f = 0; f < len; f++) begin
            k = (sel == 0 ? 16'h0 : sel < 5 ? kb(sel - 1) : kb($urandom_range(0, 1)) | kb($urandom_range(2, 3)))
                | (16'($urandom) & IGN);
            ed = 2'(m_dir); ep = m_p;
            frame(k, od, np, pos);
            vectors++;
            if (od !== ed || np != ep || (ep == 1 && pos != 1)) begin
               fails++;
               $display("FAIL random run %0d frame %0d: dir=%b pulses=%0d at=%0d, expected dir=%b pulses=%0d at=1", run, f, od, np, pos, ed, ep);
            end
            model(k);
         end
      end
   endtask
   initial begin
      test_reset();
      test_hold_up();
      test_release_repress();
      test_conflict();
      test_reverse();
      test_rst_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
